// File: rtl/poly_coef_normalize.sv
// rtl/poly_coef_normalize.sv - streams S, reduces each coefficient into [0, Q), writes R, reports true degree
module poly_coef_normalize #(
    parameter int Q  = 5167,
    parameter int W  = 26,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] deg_in,
    input  logic [W-1:0]  mem_outputS,
    output logic [AW-1:0] mem_address_oS,
    output logic [AW-1:0] mem_address_iR,
    output logic [W-1:0]  mem_inputR,
    output logic          write_enableR,
    output logic [AW-1:0] deg_out,
    output logic          zero_poly,
    output logic          range_err,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam logic signed [W:0] Q_POS = (W+1)'(Q);
    localparam logic signed [W:0] Q_NEG = (W+1)'(-Q);
    localparam logic signed [W:0] Q_TOP = (W+1)'(2*Q - 1);

    state_t        state, state_nx;
    logic [AW-1:0] n_reg;
    logic [AW:0]   k;
    logic          drain_cnt;
    logic          rd_valid;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] deg_track;
    logic          nz_seen;

    // One extra bit on the sum keeps v + Q and v - Q exact for every W-bit input.
    logic signed [W:0] v_ext, r_ext;
    logic              out_of_range;

    always_comb begin
        v_ext        = {mem_outputS[W-1], mem_outputS};
        r_ext        = v_ext;
        out_of_range = (v_ext < Q_NEG) || (v_ext > Q_TOP);
        if (v_ext < 0) begin
            r_ext = v_ext + Q_POS;
        end else if (v_ext >= Q_POS) begin
            r_ext = v_ext - Q_POS;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = READ;
            READ:  if (k == {1'b0, n_reg}) state_nx = DRAIN;
            DRAIN: if (drain_cnt) state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy           = (state == READ) || (state == DRAIN);
    assign done           = (state == FIN);
    assign mem_address_oS = k[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            n_reg          <= '0;
            k              <= '0;
            drain_cnt      <= 1'b0;
            rd_valid       <= 1'b0;
            rd_idx         <= '0;
            deg_track      <= '0;
            nz_seen        <= 1'b0;
            write_enableR  <= 1'b0;
            mem_address_iR <= '0;
            mem_inputR     <= '0;
            deg_out        <= '0;
            zero_poly      <= 1'b0;
            range_err      <= 1'b0;
        end else begin
            state <= state_nx;

            // Stage 2: read data arrives one cycle after its address; reduce and write.
            write_enableR  <= rd_valid;
            mem_address_iR <= rd_idx;
            mem_inputR     <= r_ext[W-1:0];
            if (rd_valid) begin
                if (r_ext != 0) begin
                    deg_track <= rd_idx;
                    nz_seen   <= 1'b1;
                end
                if (out_of_range) begin
                    range_err <= 1'b1;
                end
            end

            // Stage 1: address issue.
            rd_valid <= (state == READ);
            rd_idx   <= k[AW-1:0];

            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg     <= deg_in;
                        k         <= '0;
                        drain_cnt <= 1'b0;
                        deg_track <= '0;
                        nz_seen   <= 1'b0;
                        range_err <= 1'b0;
                    end
                end
                READ: begin
                    if (k != {1'b0, n_reg}) begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    // The last write-stage update landed one edge earlier, so the tracker is final here.
                    if (drain_cnt) begin
                        deg_out   <= deg_track;
                        zero_poly <= ~nz_seen;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_coef_normalize.sv
// tb/tb_poly_coef_normalize.sv - randomized self-checking bench for poly_coef_normalize
module tb_poly_coef_normalize;
    localparam int Q  = 5167;
    localparam int W  = 26;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] deg_in = '0;
    logic [W-1:0]  mem_outputS;
    logic [AW-1:0] mem_address_oS;
    logic [AW-1:0] mem_address_iR;
    logic [W-1:0]  mem_inputR;
    logic          write_enableR;
    logic [AW-1:0] deg_out;
    logic          zero_poly;
    logic          range_err;
    logic          busy;
    logic          done;

    poly_coef_normalize #(.Q(Q), .W(W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .deg_in(deg_in),
        .mem_outputS(mem_outputS), .mem_address_oS(mem_address_oS),
        .mem_address_iR(mem_address_iR), .mem_inputR(mem_inputR),
        .write_enableR(write_enableR), .deg_out(deg_out), .zero_poly(zero_poly),
        .range_err(range_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] smem [0:2047];
    int           sval [0:2047];
    int           rcap [0:2047];

    always @(posedge clk) mem_outputS <= smem[mem_address_oS];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_s(input int k, input int v);
        sval[k] = v;
        smem[k] = W'(v);
    endtask

    task automatic fill_random(input int n, input int pct_zero, input int pct_oor);
        for (int k = 0; k <= n; k++) begin
            int v;
            if ($urandom_range(99) < pct_zero) v = 0;
            else if ($urandom_range(99) < pct_oor)
                v = ($urandom_range(1) == 1) ? (2*Q + $urandom_range(5000)) : (-Q - 1 - $urandom_range(5000));
            else v = $urandom_range(3*Q - 1) - Q;
            set_s(k, v);
        end
    endtask

    // Launch one transfer of n+1 coefficients, watch every cycle, then compare with the reference model.
    task automatic run(input int n, input bit poke, input string tag);
        int  c, done_c, wcnt, bad_t, bad_b, bad_d, exp_deg, r, v;
        bit  nz, rerr;
        for (int k = 0; k <= n; k++) rcap[k] = -1;
        @(negedge clk);
        deg_in = AW'(n);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        deg_in = AW'($urandom);
        c = 0; done_c = -1; wcnt = 0; bad_t = 0; bad_b = 0;
        while (done_c < 0 && c < n + 50) begin
            @(negedge clk);
            c++;
            start = poke && (c == 2 || c == n + 2);
            if (busy !== (c >= 1 && c <= n + 3)) bad_b++;
            if (c <= n + 1 && mem_address_oS !== AW'(c - 1)) bad_t++;
            if (write_enableR === 1'b1) begin
                if (c != wcnt + 3 || int'(mem_address_iR) != wcnt) bad_t++;
                if (int'(mem_address_iR) <= n) rcap[mem_address_iR] = int'(mem_inputR);
                wcnt++;
            end
            if (done === 1'b1) done_c = c;
        end
        start = 1'b0;

        exp_deg = 0; nz = 0; rerr = 0; bad_d = 0;
        for (int k = 0; k <= n; k++) begin
            v = sval[k];
            if (v < 0) r = v + Q;
            else if (v >= Q) r = v - Q;
            else r = v;
            if (v < -Q || v > 2*Q - 1) rerr = 1;
            else if (rcap[k] != r) bad_d++;
            if (r != 0) begin
                exp_deg = k;
                nz = 1;
            end
        end
        check({tag, "_done_cycle"}, done_c, n + 4);
        check({tag, "_writes"}, wcnt, n + 1);
        check({tag, "_timing_bad"}, bad_t, 0);
        check({tag, "_busy_bad"}, bad_b, 0);
        check({tag, "_data_bad"}, bad_d, 0);
        check({tag, "_deg_out"}, deg_out, exp_deg);
        check({tag, "_zero_poly"}, zero_poly, !nz);
        check({tag, "_range_err"}, range_err, rerr);
    endtask

    initial begin
        int c, wcnt, bad_b;
        for (int k = 0; k < 2048; k++) set_s(k, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outs", {write_enableR, busy, done, deg_out, zero_poly, range_err,
                             mem_address_oS, mem_address_iR, mem_inputR}, 64'd0);

        set_s(0, 5); set_s(1, -1); set_s(2, 5166); set_s(3, -5166);
        run(3, 0, "mixed");
        check("mixed_r3", rcap[3], 1);

        set_s(0, 1); set_s(1, 0); set_s(2, 7); set_s(3, 0); set_s(4, 0);
        run(4, 0, "trailing");

        set_s(0, 0); set_s(1, 5167); set_s(2, -5167);
        run(2, 0, "to_zero");

        set_s(0, 1); set_s(1, -6000); set_s(2, 2); set_s(3, 3);
        run(3, 0, "oor");
        @(negedge clk);
        check("oor_sticky", range_err, 1);

        set_s(0, 9);
        run(0, 0, "len0");

        fill_random(20, 20, 0);
        run(20, 1, "poke");

        for (int i = 0; i < 6; i++) begin
            int n;
            n = $urandom_range(40);
            fill_random(n, 40, 10);
            run(n, i[0], $sformatf("rand%0d", i));
        end

        fill_random(2047, 10, 2);
        run(2047, 0, "len2047");

        fill_random(10, 0, 0);
        set_s(0, 3);
        @(negedge clk);
        deg_in = 10;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 5; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outs", {write_enableR, busy, done, deg_out, zero_poly, range_err,
                           mem_address_oS, mem_address_iR, mem_inputR}, 64'd0);
        wcnt = 0; bad_b = 0;
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (write_enableR !== 1'b0) wcnt++;
            if (busy !== 1'b0 || done !== 1'b0) bad_b++;
        end
        check("rst_no_writes", wcnt, 0);
        check("rst_idle", bad_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
